// File: rtl/multicyc_mem_port.sv
// multicyc_mem_port
//   Memory port between a multicycle controller/datapath and a single shared
//   instruction/data memory with a req/ack handshake. A controller strobe
//   latches address/write data, one bus transaction runs, and read data is
//   held in the memory-data register. stall holds the controller until the
//   access completes. Misaligned and rd&wr requests are rejected with err.
//
// Ports
//   clk_i        clock, all state on posedge
//   reset_i      synchronous active-high reset
//   cpu_rd_i     read strobe (fetch or load)
//   cpu_wr_i     write strobe (store)
//   cpu_addr_i   byte address, must be word aligned
//   cpu_wdata_i  store data
//   cpu_rdata_o  memory-data register, last successful read
//   stall_o      controller holds its state while high
//   err_o        one-cycle pulse: misaligned, rd&wr, or timeout
//   mem_req_o    bus request
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   bus address, stable while mem_req_o
//   mem_wdata_o  bus write data, stable while mem_req_o
//   mem_ack_i    completion; read data valid same cycle
//   mem_rdata_i  bus read data
module multicyc_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort happens on the BUSY cycle where the count (cycles already waited)
  // equals TIMEOUT-1, giving exactly TIMEOUT request cycles.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic legal, illegal, to_hit;

  assign legal   = (cpu_rd_i ^ cpu_wr_i) && (cpu_addr_i[1:0] == 2'b00);
  assign illegal = (cpu_rd_i | cpu_wr_i) && !legal;
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Stall rises in the strobe cycle itself so the controller never advances
  // past an accepted request; DONE is the single cycle it may move on.
  assign stall_o = (state_q == BUSY) || ((state_q == IDLE) && legal);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (legal) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            we_q    <= cpu_wr_i;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= BUSY;
          end else if (illegal) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!we_q) rdata_q <= mem_rdata_i;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;  // saturate
            if (to_hit) begin
              err_q   <= 1'b1;
              req_q   <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        // Strobes still presented by the controller are ignored here.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_multicyc_mem_port.sv
module tb_multicyc_mem_port;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, err, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  multicyc_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .stall_o(stall), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  txn_t        cur;
  int          nchk = 0, nfail = 0;
  int          n_txn = 0, exp_txn = 0, req_cycles = 0;
  logic        req_prev = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: each new request is popped from the scoreboard and its
  // fields compared; later request cycles must keep the same fields.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (mem_req && !req_prev) begin
        n_txn++;
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          cur = sb.pop_front();
          chk("bus_we",    64'(mem_we),    64'(cur.we));
          chk("bus_addr",  64'(mem_addr),  64'(cur.addr));
          if (cur.we) chk("bus_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
      end else if (mem_req) begin
        chk("hold_addr", 64'(mem_addr), 64'(cur.addr));
        chk("hold_we",   64'(mem_we),   64'(cur.we));
        if (cur.we) chk("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
      end
      if (mem_req) req_cycles++;
      req_prev = mem_req;
    end
  end

  // One complete access as the controller sees it: strobe held through DONE,
  // dropped in the following IDLE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input bit ack);
    int busy;
    int rc0;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    sb.push_back('{we: wr, addr: addr, wdata: wdata});
    exp_txn++;
    rc0 = req_cycles;
    #1;
    chk("strobe_stall", 64'(stall),   64'd1);
    chk("strobe_req",   64'(mem_req), 64'd0);
    busy = ack ? waits + 1 : TO;
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      mem_ack   = ack && (i == waits);
      mem_rdata = (ack && i == waits) ? rdata : ~rdata;
      #1;
      chk("busy_stall", 64'(stall),   64'd1);
      chk("busy_req",   64'(mem_req), 64'd1);
      chk("busy_err",   64'(err),     64'd0);
    end
    if (ack && rd) exp_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("done_stall", 64'(stall),     64'd0);
    chk("done_req",   64'(mem_req),   64'd0);
    chk("done_err",   64'(err),       64'(!ack));
    chk("done_rdata", 64'(cpu_rdata), 64'(exp_rdata));
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    #1;
    chk("idle_stall",  64'(stall),       64'd0);
    chk("idle_req",    64'(mem_req),     64'd0);
    chk("idle_err",    64'(err),         64'd0);
    chk("txn_count",   64'(n_txn),       64'(exp_txn));
    chk("req_cycles",  64'(req_cycles - rc0), 64'(busy));
  endtask

  task automatic reject(input bit rd, input bit wr, input logic [31:0] addr);
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = 32'hA5A5_A5A5;
    #1;
    chk("rej_stall", 64'(stall),   64'd0);
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    #1;
    chk("rej_err",   64'(err),     64'd1);
    chk("rej_req",   64'(mem_req), 64'd0);
    @(negedge clk);
    #1;
    chk("rej_err_clr", 64'(err),   64'd0);
    chk("rej_txn",   64'(n_txn),   64'(exp_txn));
  endtask

  initial begin
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   64'(mem_req),   64'd0);
    chk("rst_stall", 64'(stall),     64'd0);
    chk("rst_err",   64'(err),       64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_we",    64'(mem_we),    64'd0);
    @(negedge clk);
    reset = 1'b0;

    // read, ack in first BUSY cycle
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    // write, ack after 3 wait cycles
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0BAD_F00D, 3, 1'b1);
    chk("wr_keeps_rdata", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);

    // read that never gets an ack, then a late ack in IDLE
    access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h7777_7777, 0, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    chk("late_ack_stall", 64'(stall), 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_req",   64'(mem_req),   64'd0);
    chk("late_ack_rdata", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("late_ack_err",   64'(err),       64'd0);

    // rejected requests
    reject(1'b1, 1'b0, 32'h0000_0006);
    reject(1'b1, 1'b1, 32'h0000_0008);

    // reset in the second BUSY cycle
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0050;
    sb.push_back('{we: 1'b0, addr: 32'h0000_0050, wdata: 32'h0});
    exp_txn++;
    @(negedge clk);
    mem_rdata = 32'h5555_5555;
    #1;
    chk("rb_busy1_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rb_busy2_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b0; cpu_rd = 1'b0;
    exp_rdata = '0;
    #1;
    chk("rb_req",   64'(mem_req),   64'd0);
    chk("rb_stall", 64'(stall),     64'd0);
    chk("rb_err",   64'(err),       64'd0);
    chk("rb_rdata", 64'(cpu_rdata), 64'd0);
    chk("rb_addr",  64'(mem_addr),  64'd0);
    @(negedge clk);
    #1;
    chk("rb_err2",  64'(err),       64'd0);
    chk("rb_txn",   64'(n_txn),     64'(exp_txn));

    // normal read after reset
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
    // back-to-back accesses: each holds its strobe through DONE
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0101_0101, 0, 1'b1);
    access(1'b0, 1'b1, 32'h0000_0104, 32'hFEED_FACE, 32'h0, 2, 1'b1);
    chk("b2b_rdata", 64'(cpu_rdata), 64'h0000_0000_0101_0101);
    chk("sb_empty",  64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
